// File: rtl/udma_cfg_sequencer.sv
// udma_cfg_sequencer
// Initiator for the uDMA 5-bit configuration bus. Host commands (register
// writes and reads) are queued in a command FIFO and issued one at a time on
// the cfg_* bus, waiting for the responder's ready. Read data comes back
// through a response FIFO with a valid/ready handshake.
//
// Optional feature: define UDMA_CFG_SEQ_TIMEOUT_EN to abort transactions that
// stall for TIMEOUT_CYCLES cycles (sticky err_o, aborted reads return
// 32'hDEADBEEF). Without it, ISSUE waits indefinitely and err_o is tied 0.
//
// Ports:
//   clk_i, rstn_i                      clock, asynchronous active-low reset
//   cmd_valid_i/cmd_ready_o            command handshake (ready = FIFO not full)
//   cmd_rwn_i, cmd_addr_i, cmd_data_i  command payload (1 = read)
//   rsp_valid_o/rsp_ready_i            response handshake
//   rsp_data_o                         read data at response FIFO head (0 if empty)
//   cfg_valid_o, cfg_rwn_o, cfg_addr_o, cfg_data_o   cfg-bus request
//   cfg_data_i, cfg_ready_i            cfg-bus read data and completion
//   busy_o                             command pending or in flight
//   err_o, err_clr_i                   sticky timeout flag and its clear
//
// FSM states:
//   state   | meaning
//   IDLE    | no transaction on the bus; issues the command FIFO head when allowed
//   ISSUE   | cfg_valid_o high, outputs held until cfg_ready_i (or timeout)
module udma_cfg_sequencer #(
    parameter int CMD_DEPTH      = 4,
    parameter int RSP_DEPTH      = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_rwn_i,
    input  logic [4:0]  cmd_addr_i,
    input  logic [31:0] cmd_data_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_data_o,
    output logic        cfg_valid_o,
    output logic        cfg_rwn_o,
    output logic [4:0]  cfg_addr_o,
    output logic [31:0] cfg_data_o,
    input  logic [31:0] cfg_data_i,
    input  logic        cfg_ready_i,
    output logic        busy_o,
    output logic        err_o,
    input  logic        err_clr_i
);

    localparam int CMD_AW = $clog2(CMD_DEPTH);
    localparam int CMD_CW = CMD_AW + 1;
    localparam int RSP_AW = $clog2(RSP_DEPTH);
    localparam int RSP_CW = RSP_AW + 1;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_ISSUE = 1'b1;

    logic [0:0]        state_q;

    logic [37:0]       cmd_mem [CMD_DEPTH];
    logic [CMD_AW-1:0] cmd_wr_ptr_q, cmd_rd_ptr_q;
    logic [CMD_CW-1:0] cmd_count_q;
    logic              cmd_empty, cmd_full, cmd_push, cmd_pop;
    logic [37:0]       cmd_head;

    logic [31:0]       rsp_mem [RSP_DEPTH];
    logic [RSP_AW-1:0] rsp_wr_ptr_q, rsp_rd_ptr_q;
    logic [RSP_CW-1:0] rsp_count_q;
    logic              rsp_empty, rsp_full, rsp_push, rsp_pop;
    logic [31:0]       rsp_push_data;

    logic              cfg_rwn_q;
    logic [4:0]        cfg_addr_q;
    logic [31:0]       cfg_data_q;
    logic              txn_done, txn_abort;

    // Command FIFO
    assign cmd_empty   = (cmd_count_q == '0);
    assign cmd_full    = (cmd_count_q == CMD_CW'(CMD_DEPTH));
    assign cmd_ready_o = ~cmd_full;
    assign cmd_push    = cmd_valid_i & ~cmd_full;
    assign cmd_head    = cmd_mem[cmd_rd_ptr_q];

    // A read is only issued when a response slot is free, so the single
    // outstanding transaction can always push its response. A blocked read
    // also blocks everything queued behind it.
    assign cmd_pop = (state_q == S_IDLE) & ~cmd_empty & (~cmd_head[37] | ~rsp_full);

    always_ff @(posedge clk_i) begin
        if (cmd_push) cmd_mem[cmd_wr_ptr_q] <= {cmd_rwn_i, cmd_addr_i, cmd_data_i};
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cmd_wr_ptr_q <= '0;
            cmd_rd_ptr_q <= '0;
            cmd_count_q  <= '0;
        end else begin
            if (cmd_push) cmd_wr_ptr_q <= cmd_wr_ptr_q + 1'b1;
            if (cmd_pop)  cmd_rd_ptr_q <= cmd_rd_ptr_q + 1'b1;
            case ({cmd_push, cmd_pop})
                2'b10:   cmd_count_q <= cmd_count_q + 1'b1;
                2'b01:   cmd_count_q <= cmd_count_q - 1'b1;
                default: cmd_count_q <= cmd_count_q;
            endcase
        end
    end

    // Transaction control
    assign txn_done = (state_q == S_ISSUE) & cfg_ready_i;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= S_IDLE;
            cfg_rwn_q  <= 1'b0;
            cfg_addr_q <= '0;
            cfg_data_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cmd_pop) begin
                        state_q    <= S_ISSUE;
                        cfg_rwn_q  <= cmd_head[37];
                        cfg_addr_q <= cmd_head[36:32];
                        cfg_data_q <= cmd_head[37] ? 32'h0 : cmd_head[31:0];
                    end
                end
                S_ISSUE: begin
                    if (txn_done | txn_abort) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign cfg_valid_o = (state_q == S_ISSUE);
    assign cfg_rwn_o   = cfg_rwn_q;
    assign cfg_addr_o  = cfg_addr_q;
    assign cfg_data_o  = cfg_data_q;
    assign busy_o      = (state_q == S_ISSUE) | ~cmd_empty;

    // Response FIFO
    assign rsp_empty     = (rsp_count_q == '0);
    assign rsp_full      = (rsp_count_q == RSP_CW'(RSP_DEPTH));
    assign rsp_push      = (txn_done | txn_abort) & cfg_rwn_q;
    assign rsp_push_data = txn_abort ? 32'hDEAD_BEEF : cfg_data_i;
    assign rsp_pop       = ~rsp_empty & rsp_ready_i;
    assign rsp_valid_o   = ~rsp_empty;
    assign rsp_data_o    = rsp_empty ? 32'h0 : rsp_mem[rsp_rd_ptr_q];

    always_ff @(posedge clk_i) begin
        if (rsp_push) rsp_mem[rsp_wr_ptr_q] <= rsp_push_data;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rsp_wr_ptr_q <= '0;
            rsp_rd_ptr_q <= '0;
            rsp_count_q  <= '0;
        end else begin
            if (rsp_push) rsp_wr_ptr_q <= rsp_wr_ptr_q + 1'b1;
            if (rsp_pop)  rsp_rd_ptr_q <= rsp_rd_ptr_q + 1'b1;
            case ({rsp_push, rsp_pop})
                2'b10:   rsp_count_q <= rsp_count_q + 1'b1;
                2'b01:   rsp_count_q <= rsp_count_q - 1'b1;
                default: rsp_count_q <= rsp_count_q;
            endcase
        end
    end

`ifdef UDMA_CFG_SEQ_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] to_cnt_q;
    logic            err_q;

    // A ready in the terminal cycle wins over the abort.
    assign txn_abort = (state_q == S_ISSUE) & ~cfg_ready_i
                     & (to_cnt_q == TO_W'(TIMEOUT_CYCLES));

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            to_cnt_q <= '0;
        end else if (cmd_pop) begin
            to_cnt_q <= '0;
        end else if ((state_q == S_ISSUE) && !cfg_ready_i && !txn_abort) begin
            to_cnt_q <= to_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i)        err_q <= 1'b0;
        else if (txn_abort) err_q <= 1'b1;
        else if (err_clr_i) err_q <= 1'b0;
    end

    assign err_o = err_q;
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    logic unused_err_clr;

    assign txn_abort      = 1'b0;
    assign err_o          = 1'b0;
    assign unused_err_clr = err_clr_i;
`endif

endmodule

// File: tb/tb_udma_cfg_sequencer.sv
module tb_udma_cfg_sequencer;

    localparam int CMD_DEPTH      = 4;
    localparam int RSP_DEPTH      = 4;
    localparam int TIMEOUT_CYCLES = 8;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic        cmd_valid_i, cmd_ready_o, cmd_rwn_i;
    logic [4:0]  cmd_addr_i;
    logic [31:0] cmd_data_i;
    logic        rsp_valid_o, rsp_ready_i;
    logic [31:0] rsp_data_o;
    logic        cfg_valid_o, cfg_rwn_o;
    logic [4:0]  cfg_addr_o;
    logic [31:0] cfg_data_o, cfg_data_i;
    logic        cfg_ready_i, busy_o, err_o, err_clr_i;

    udma_cfg_sequencer #(
        .CMD_DEPTH(CMD_DEPTH), .RSP_DEPTH(RSP_DEPTH), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk_i(clk_i), .rstn_i(rstn_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_rwn_i(cmd_rwn_i),
        .cmd_addr_i(cmd_addr_i), .cmd_data_i(cmd_data_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_data_o(rsp_data_o),
        .cfg_valid_o(cfg_valid_o), .cfg_rwn_o(cfg_rwn_o), .cfg_addr_o(cfg_addr_o),
        .cfg_data_o(cfg_data_o), .cfg_data_i(cfg_data_i), .cfg_ready_i(cfg_ready_i),
        .busy_o(busy_o), .err_o(err_o), .err_clr_i(err_clr_i)
    );

    always #5 clk_i = ~clk_i;

    // Responder: either a directly driven read value or a register file.
    logic        use_regs;
    logic [31:0] cfg_data_drv;
    logic [31:0] resp_regs [32];
    assign cfg_data_i = use_regs ? resp_regs[cfg_addr_o] : cfg_data_drv;

    int txn_cnt = 0;
    always @(posedge clk_i) if (rstn_i && cfg_valid_o && cfg_ready_i) txn_cnt++;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    task automatic push_cmd(input logic rwn, input logic [4:0] a, input logic [31:0] d);
        cmd_valid_i = 1'b1; cmd_rwn_i = rwn; cmd_addr_i = a; cmd_data_i = d;
        for (int i = 0; i < 50; i++) begin
            if (cmd_ready_o) begin
                tick();
                cmd_valid_i = 1'b0;
                return;
            end
            tick();
        end
        cmd_valid_i = 1'b0;
        check("push_bound", 64'd0, 64'd1);
    endtask

    typedef struct {
        logic        rwn;
        logic [4:0]  addr;
        logic [31:0] data;
        int          waits;
        logic [31:0] rd;
        logic [31:0] exp_cfg_data;
        logic [31:0] exp_rsp;
    } vec_t;

    typedef struct packed {
        logic        rwn;
        logic [4:0]  addr;
        logic [31:0] data;
    } cmd_t;

    vec_t vecs [5];

    initial begin
        logic [31:0] model_regs [32];
        logic [31:0] exp_rd_q [$];
        logic [31:0] rsp_q [$];
        cmd_t        cmd_q [$];
        cmd_t        f;
        int          acc, k, pending, stall_cnt;
        logic        prev_stall, last_comp, acc_e, comp_e, pop_e;
        logic [38:0] prev_out;

        vecs[0] = '{1'b0, 5'h00, 32'h0000_00A5, 0, 32'h0BAD_0BAD, 32'h0000_00A5, 32'h0};
        vecs[1] = '{1'b1, 5'h14, 32'hFFFF_FFFF, 3, 32'h1234_5678, 32'h0, 32'h1234_5678};
        vecs[2] = '{1'b0, 5'h1F, 32'hDEAD_0001, 2, 32'h0BAD_0BAD, 32'hDEAD_0001, 32'h0};
        vecs[3] = '{1'b1, 5'h01, 32'h0000_5555, 0, 32'hCAFE_F00D, 32'h0, 32'hCAFE_F00D};
        vecs[4] = '{1'b0, 5'h0A, 32'h8000_0000, 1, 32'h0BAD_0BAD, 32'h8000_0000, 32'h0};

        rstn_i = 1'b0; cmd_valid_i = 1'b0; cmd_rwn_i = 1'b0; cmd_addr_i = '0;
        cmd_data_i = '0; rsp_ready_i = 1'b0; cfg_ready_i = 1'b0; err_clr_i = 1'b0;
        use_regs = 1'b0; cfg_data_drv = '0;
        for (int i = 0; i < 32; i++) resp_regs[i] = 32'hB000_0000 + 32'(i);

        // Reset state
        #12;
        check("rst_outputs", {cfg_valid_o, cfg_rwn_o, cfg_addr_o, cfg_data_o, rsp_valid_o, busy_o, err_o},
              {1'b0, 1'b0, 5'h0, 32'h0, 1'b0, 1'b0, 1'b0});
        check("rst_rsp_data", rsp_data_o, 32'h0);
        check("rst_cmd_ready", cmd_ready_o, 1'b1);
        tick();
        rstn_i = 1'b1;
        tick();

        // Table-driven single transactions
        for (int v = 0; v < 5; v++) begin
            cmd_valid_i = 1'b1; cmd_rwn_i = vecs[v].rwn;
            cmd_addr_i = vecs[v].addr; cmd_data_i = vecs[v].data;
            check("vec_cmd_ready", cmd_ready_o, 1'b1);
            tick();
            cmd_valid_i = 1'b0;
            check("vec_lat_t1", cfg_valid_o, 1'b0);
            check("vec_busy_t1", busy_o, 1'b1);
            tick();
            for (int w = 0; w <= vecs[v].waits; w++) begin
                check("vec_cfg_out", {cfg_valid_o, cfg_rwn_o, cfg_addr_o, cfg_data_o},
                      {1'b1, vecs[v].rwn, vecs[v].addr, vecs[v].exp_cfg_data});
                if (w == vecs[v].waits) begin
                    cfg_ready_i = 1'b1; cfg_data_drv = vecs[v].rd;
                end else begin
                    cfg_data_drv = $urandom;
                end
                tick();
            end
            cfg_ready_i = 1'b0;
            check("vec_valid_drop", cfg_valid_o, 1'b0);
            check("vec_rsp_valid", rsp_valid_o, vecs[v].rwn);
            check("vec_rsp_data", rsp_data_o, vecs[v].exp_rsp);
            check("vec_busy_end", busy_o, 1'b0);
            if (vecs[v].rwn) begin
                rsp_ready_i = 1'b1;
                tick();
                rsp_ready_i = 1'b0;
                check("vec_rsp_pop", rsp_valid_o, 1'b0);
            end
            tick();
        end

        // Response backpressure: six reads, only four can be issued
        use_regs = 1'b1; cfg_ready_i = 1'b1; rsp_ready_i = 1'b0;
        k = txn_cnt;
        for (int i = 0; i < 6; i++) push_cmd(1'b1, 5'(3 + i), 32'hFFFF_0000);
        for (int i = 0; i < 10; i++) tick();
        check("bp_txn_count", 64'(txn_cnt - k), 64'd4);
        check("bp_busy", busy_o, 1'b1);
        check("bp_cmd_ready", cmd_ready_o, 1'b1);
        check("bp_rsp_head", {rsp_valid_o, rsp_data_o}, {1'b1, 32'hB000_0003});
        rsp_ready_i = 1'b1;
        acc = 0;
        for (int i = 0; i < 40; i++) begin
            if (rsp_valid_o) begin
                check("bp_rsp_order", rsp_data_o, 32'hB000_0003 + 32'(acc));
                acc++;
            end
            tick();
            if (acc == 6) break;
        end
        rsp_ready_i = 1'b0;
        check("bp_rsp_total", 64'(acc), 64'd6);
        check("bp_txn_total", 64'(txn_cnt - k), 64'd6);
        check("bp_idle", {busy_o, rsp_valid_o}, 2'b00);

        // Command FIFO full: 4 queued + 1 in flight
        use_regs = 1'b0; cfg_ready_i = 1'b0;
        acc = 0; k = -1;
        cmd_valid_i = 1'b1; cmd_rwn_i = 1'b0;
        for (int i = 0; i < 12; i++) begin
            cmd_addr_i = 5'(i); cmd_data_i = 32'h100 + 32'(i);
            if (cmd_ready_o) acc++;
            tick();
            if (acc == 5) begin
                k = i;
                break;
            end
        end
        cmd_valid_i = 1'b0;
        check("full_accepted", 64'(acc), 64'd5);
        check("full_back_to_back", 64'(k), 64'd4);
        check("full_ready_low", cmd_ready_o, 1'b0);
        tick();
        check("full_ready_hold", {cmd_ready_o, cfg_valid_o, busy_o}, 3'b011);
        cfg_ready_i = 1'b1;
        tick();
        cfg_ready_i = 1'b0;
        check("full_ready_at_done", {cmd_ready_o, cfg_valid_o}, 2'b00);
        tick();
        check("full_ready_back", {cmd_ready_o, cfg_valid_o, cfg_addr_o}, {1'b1, 1'b1, 5'h1});
        cfg_ready_i = 1'b1;
        for (int i = 0; i < 40 && busy_o; i++) tick();
        cfg_ready_i = 1'b0;
        check("full_drained", busy_o, 1'b0);
        tick();

        // Reset in the middle of a read with a response already queued
        cfg_data_drv = 32'h7777_0001;
        push_cmd(1'b1, 5'h02, 32'h0);
        tick();
        cfg_ready_i = 1'b1;
        tick();
        cfg_ready_i = 1'b0;
        check("mid_rsp_queued", rsp_valid_o, 1'b1);
        push_cmd(1'b1, 5'h03, 32'h0);
        tick();
        check("mid_in_issue", cfg_valid_o, 1'b1);
        rstn_i = 1'b0;
        #1;
        check("mid_rst_outputs", {cfg_valid_o, rsp_valid_o, busy_o, cmd_ready_o, err_o}, 5'b00010);
        check("mid_rst_cfg", {cfg_rwn_o, cfg_addr_o, cfg_data_o, rsp_data_o}, 70'h0);
        cfg_ready_i = 1'b1;
        tick();
        tick();
        rstn_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("mid_after_release", {cfg_valid_o, rsp_valid_o, busy_o}, 3'b000);
        end
        cfg_ready_i = 1'b0;

`ifdef UDMA_CFG_SEQ_TIMEOUT_EN
        // Timeout abort of a stalled read
        push_cmd(1'b1, 5'h04, 32'h0);
        tick();
        k = 0;
        for (int i = 0; i < 20; i++) begin
            if (!cfg_valid_o) break;
            k++;
            tick();
        end
        check("to_valid_cycles", 64'(k), 64'(TIMEOUT_CYCLES + 1));
        check("to_err_set", err_o, 1'b1);
        check("to_rsp", {rsp_valid_o, rsp_data_o}, {1'b1, 32'hDEAD_BEEF});
        err_clr_i = 1'b1; rsp_ready_i = 1'b1;
        tick();
        err_clr_i = 1'b0; rsp_ready_i = 1'b0;
        check("to_err_clr", {err_o, rsp_valid_o}, 2'b00);
`endif

        // Randomized traffic against a register-file reference model
        use_regs = 1'b1;
        for (int i = 0; i < 32; i++) begin
            resp_regs[i]  = 32'h5A00_0000 + 32'(i * 3);
            model_regs[i] = 32'h5A00_0000 + 32'(i * 3);
        end
        pending = 0; stall_cnt = 0; prev_stall = 1'b0; last_comp = 1'b0; prev_out = '0;
        for (int c = 0; c < 3000; c++) begin
            check("rnd_busy", busy_o, 1'(pending > 0));
            check("rnd_rsp_valid", rsp_valid_o, 1'(rsp_q.size() > 0));
            check("rnd_rsp_data", rsp_data_o, (rsp_q.size() > 0) ? rsp_q[0] : 32'h0);
            check("rnd_err", err_o, 1'b0);
            if (prev_stall) check("rnd_stall_stable", {cfg_valid_o, cfg_rwn_o, cfg_addr_o, cfg_data_o}, prev_out);
            if (last_comp) check("rnd_gap", cfg_valid_o, 1'b0);

            if (c < 2940) begin
                cmd_valid_i = 1'($urandom_range(0, 1));
                cmd_rwn_i   = 1'($urandom_range(0, 1));
                cmd_addr_i  = 5'($urandom_range(0, 7));
                cmd_data_i  = $urandom;
                cfg_ready_i = (stall_cnt >= 4) ? 1'b1 : 1'($urandom_range(0, 2) == 0);
                rsp_ready_i = 1'($urandom_range(0, 3) == 0);
            end else begin
                cmd_valid_i = 1'b0; cfg_ready_i = 1'b1; rsp_ready_i = 1'b1;
            end
            err_clr_i = 1'($urandom_range(0, 1));

            acc_e  = cmd_valid_i & cmd_ready_o;
            comp_e = cfg_valid_o & cfg_ready_i;
            pop_e  = rsp_valid_o & rsp_ready_i;
            if (comp_e) begin
                if (cmd_q.size() == 0) begin
                    check("rnd_unexpected_txn", 64'd1, 64'd0);
                end else begin
                    f = cmd_q.pop_front();
                    check("rnd_txn", {cfg_rwn_o, cfg_addr_o, cfg_data_o},
                          {f.rwn, f.addr, f.rwn ? 32'h0 : f.data});
                    if (f.rwn) rsp_q.push_back(exp_rd_q.pop_front());
                    pending--;
                end
                if (!cfg_rwn_o) resp_regs[cfg_addr_o] = cfg_data_o;
            end
            if (pop_e && rsp_q.size() > 0) void'(rsp_q.pop_front());
            if (acc_e) begin
                cmd_q.push_back({cmd_rwn_i, cmd_addr_i, cmd_data_i});
                if (cmd_rwn_i) exp_rd_q.push_back(model_regs[cmd_addr_i]);
                else model_regs[cmd_addr_i] = cmd_data_i;
                pending++;
            end
            stall_cnt  = (cfg_valid_o && !cfg_ready_i) ? stall_cnt + 1 : 0;
            prev_stall = cfg_valid_o & ~cfg_ready_i;
            prev_out   = {cfg_valid_o, cfg_rwn_o, cfg_addr_o, cfg_data_o};
            last_comp  = comp_e;
            tick();
        end
        err_clr_i = 1'b0;
        check("rnd_drained", {64'(pending), 64'(rsp_q.size())}, 128'h0);
        check("rnd_final_idle", {busy_o, rsp_valid_o, cfg_valid_o}, 3'b000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/udma_cfg_sequencer.md
# udma_cfg_sequencer

Initiator for the uDMA 5-bit configuration bus (cfg_addr/cfg_data/cfg_valid/cfg_rwn/cfg_ready), driving the uDMA control register block and any other cfg-bus responder.

- Commands (register writes and reads) are queued in a command FIFO and issued one at a time.
- The block waits for the responder's ready on each transaction.
- Read data is returned through a response FIFO with a valid/ready handshake.
- It sits between a host-side command source (CPU bridge or boot loader) and the cfg-bus responders.

## Interface
- CMD_DEPTH, 4, command FIFO entries (power of 2, ≥2)
- RSP_DEPTH, 4, response FIFO entries (power of 2, ≥2)
- TIMEOUT_CYCLES, 255, stall limit in cycles (used only with the timeout macro)
- clk_i  in  1  clock
- rstn_i  in  1  asynchronous active-low reset
- cmd_valid_i  in  1  command offered
- cmd_ready_o  out  1  command FIFO not full
- cmd_rwn_i  in  1  1 = read, 0 = write
- cmd_addr_i  in  5  register address
- cmd_data_i  in  32  write data (ignored for reads)
- rsp_valid_o  out  1  response FIFO not empty
- rsp_ready_i  in  1  response consumer ready
- rsp_data_o  out  32  read data at FIFO head
- cfg_valid_o  out  1  transaction request
- cfg_rwn_o  out  1  1 = read
- cfg_addr_o  out  5  address
- cfg_data_o  out  32  write data
- cfg_data_i  in  32  read data, sampled when cfg_valid_o & cfg_ready_i & cfg_rwn_o
- cfg_ready_i  in  1  responder completes the transaction this cycle
- busy_o  out  1  command pending or in flight
- err_o  out  1  sticky timeout flag
- err_clr_i  in  1  clears err_o

## Operation
- **Command FIFO:**
  - Stores {rwn, addr, data}; push on cmd_valid_i & cmd_ready_o.
  - cmd_ready_o = !full (combinational; 1 out of reset).
- **FSM states:** IDLE, ISSUE.
- **IDLE → ISSUE:** command FIFO not empty and (head is a write, or response FIFO not full).
  - Pop the head into the cfg_* output registers and set cfg_valid_o = 1.
  - Reads drive cfg_data_o = 0.
  - A read at the head with the response FIFO full stalls in IDLE, and holds all later commands behind it (strict in-order).
- **ISSUE, cfg_ready_i = 0:** hold all cfg_* outputs stable.
- **ISSUE, cfg_ready_i = 1:** the transaction completes this cycle.
  - Reads push cfg_data_i into the response FIFO at this edge.
  - cfg_valid_o → 0 and the FSM returns to IDLE.
- **In-flight limit:** at most one transaction outstanding. The space check at issue guarantees a response FIFO slot, and pops only ever free space, so the response FIFO cannot overflow.
- **Response FIFO:**
  - rsp_valid_o = !empty; rsp_data_o = head when non-empty, 0 when empty.
  - Pop on rsp_valid_o & rsp_ready_i.
  - Simultaneous push and pop keeps the count unchanged.
- **FIFO pointers** wrap modulo depth; counts are $clog2(DEPTH)+1 bits wide.
- **busy_o** = (state == ISSUE) | command FIFO not empty.
- **Reset (asynchronous, any state, including mid-transaction):**
  - FSM → IDLE; both FIFOs emptied.
  - cfg_valid_o, cfg_rwn_o, cfg_addr_o, cfg_data_o, rsp_valid_o, rsp_data_o, busy_o, err_o = 0; cmd_ready_o = 1.
  - FIFO storage is not reset.

## Timing
- Command handshake in cycle t → cfg_valid_o = 1 in cycle t+2 (FIFO write at the end of t, IDLE sees non-empty in t+1, registered load).
- cfg_valid_o & cfg_ready_i in cycle t:
  - rsp_valid_o = 1 in cycle t+1 for a read;
  - next cfg_valid_o no earlier than t+2.
- Peak throughput: one transaction per 2 cycles. cfg_valid_o always drops for at least one cycle between transactions.
- A zero-wait responder (cfg_ready_i tied 1) completes in the first cycle cfg_valid_o is high.
- err_clr_i and a timeout in the same cycle: set wins.

## Configuration
- **UDMA_CFG_SEQ_TIMEOUT_EN defined:**
  - A counter of $clog2(TIMEOUT_CYCLES+1) bits clears on entering ISSUE and increments each ISSUE cycle with cfg_ready_i = 0.
  - When the counter equals TIMEOUT_CYCLES with cfg_ready_i still 0, the transaction is aborted: cfg_valid_o → 0, FSM → IDLE, err_o set (sticky until err_clr_i).
  - An aborted read pushes 32'hDEADBEEF so response ordering is preserved.
  - cfg_ready_i = 1 in the terminal cycle completes normally, with no error.
- **Macro undefined:** ISSUE waits indefinitely; err_o is tied 0; err_clr_i is ignored; TIMEOUT_CYCLES is unused.

## Test plan
- **Write, zero-wait responder:** write addr 5'h00 data 32'h0000_00A5 with cfg_ready_i = 1 → cfg_valid_o high exactly one cycle, 2 cycles after the handshake; cfg_rwn_o = 0, cfg_addr_o = 0, cfg_data_o = 32'hA5; no response pushed.
- **Stalled read:** read addr 5'h14 with cfg_ready_i held 0 for 3 cycles and cfg_data_i = 32'h1234_5678 in the ready cycle → outputs stable for 4 cycles; rsp_data_o = 32'h1234_5678 with rsp_valid_o the next cycle.
- **Backpressure:** rsp_ready_i = 0, RSP_DEPTH = 4, six reads issued → exactly 4 cfg transactions, busy_o stays 1, cmd FIFO holds 2. Releasing rsp_ready_i drains all 6 responses in order.
- **Command FIFO full:** 5 back-to-back commands offered with cfg_ready_i = 0 → cmd_ready_o deasserts after 5 accepted (4 in FIFO + 1 in flight) and reasserts one cycle after the first completion pops.
- **Reset mid-read:** rstn_i asserted during ISSUE → cfg_valid_o and rsp_valid_o = 0 immediately, busy_o = 0, cmd_ready_o = 1; no response after release.
- **Timeout (UDMA_CFG_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES = 8):** read with cfg_ready_i stuck 0 → abort after the 8-cycle limit, err_o = 1, response 32'hDEADBEEF; err_clr_i clears err_o the next cycle.
